// File: rtl/memory_read_checker.sv
// memory_read_checker: scans a synchronous-read memory from address 0 up to
// LAST_ADDR. Each word is handed downstream through a valid/ready port and,
// when CHECK_IDENTITY is set, compared against its own address. Mismatch
// statistics stay held after a scan until the next accepted start.
module memory_read_checker #(
    parameter logic [7:0] LAST_ADDR      = 8'hFF,
    parameter bit         CHECK_IDENTITY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] address,
    output logic       wren,
    input  logic [7:0] q,
    output logic [7:0] out_data,
    output logic [7:0] out_addr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       finish,
    output logic       mismatch,
    output logic [8:0] err_count,
    output logic [7:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] address_q, address_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] out_addr_q, out_addr_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       finish_q, finish_d;
    logic       mismatch_q, mismatch_d;
    logic [8:0] err_count_q, err_count_d;
    logic [7:0] first_err_addr_q, first_err_addr_d;

    // Next-state, datapath capture and statistics update; the status
    // outputs are derived from the next state so they are registered.
    always_comb begin
        state_d          = state_q;
        address_d        = address_q;
        out_data_d       = out_data_q;
        out_addr_d       = out_addr_q;
        mismatch_d       = mismatch_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;

        case (state_q)
            S_IDLE: begin
                address_d = 8'h00;
                if (start) begin
                    state_d          = S_ISSUE;
                    mismatch_d       = 1'b0;
                    err_count_d      = 9'd0;
                    first_err_addr_d = 8'h00;
                end
            end
            S_ISSUE: begin
                // Address is held this cycle; the memory registers it at the edge.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                out_data_d = q;
                out_addr_d = address_q;
                if (CHECK_IDENTITY && (q != address_q)) begin
                    mismatch_d = 1'b1;
                    // Saturate rather than wrap, even though a 256-word scan fits.
                    err_count_d = (err_count_q == 9'h1FF) ? err_count_q
                                                          : err_count_q + 9'd1;
                    if (!mismatch_q) begin
                        first_err_addr_d = address_q;
                    end
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                // Holding here neither re-reads memory nor re-compares.
                if (out_ready) begin
                    if (address_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        address_d = address_q + 8'd1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                address_d = 8'h00;
            end
        endcase

        out_valid_d = (state_d == S_PRESENT);
        busy_d      = (state_d != S_IDLE);
        finish_d    = (state_d == S_DONE);
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            address_q        <= 8'h00;
            out_data_q       <= 8'h00;
            out_addr_q       <= 8'h00;
            out_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            finish_q         <= 1'b0;
            mismatch_q       <= 1'b0;
            err_count_q      <= 9'd0;
            first_err_addr_q <= 8'h00;
        end else begin
            state_q          <= state_d;
            address_q        <= address_d;
            out_data_q       <= out_data_d;
            out_addr_q       <= out_addr_d;
            out_valid_q      <= out_valid_d;
            busy_q           <= busy_d;
            finish_q         <= finish_d;
            mismatch_q       <= mismatch_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign address        = address_q;
    assign wren           = 1'b0;
    assign out_data       = out_data_q;
    assign out_addr       = out_addr_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign finish         = finish_q;
    assign mismatch       = mismatch_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_memory_read_checker.sv
// Testbench for memory_read_checker: a registered-read memory model feeds the
// DUT, expected words are queued when a scan starts and a monitor pops and
// compares every word the DUT hands off.
module tb_memory_read_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] address;
    logic       wren;
    logic [7:0] mem_q;
    logic [7:0] out_data;
    logic [7:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       finish;
    logic       mismatch;
    logic [8:0] err_count;
    logic [7:0] first_err_addr;

    int vectors = 0;
    int miscompares = 0;
    logic wren_seen = 1'b0;

    logic [7:0]  mem [256];
    logic [15:0] expq [$];

    memory_read_checker #(.LAST_ADDR(8'hFF), .CHECK_IDENTITY(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .address(address), .wren(wren),
        .q(mem_q), .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .finish(finish), .mismatch(mismatch),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // Memory with one cycle of read latency.
    always @(posedge clk) mem_q <= mem[address];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (wren !== 1'b0) wren_seen = 1'b1;
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL word: unexpected word addr %0h data %0h", out_addr, out_data);
            end else begin
                logic [15:0] e;
                e = expq.pop_front();
                if ({out_addr, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL word: got addr %0h data %0h expected addr %0h data %0h",
                             out_addr, out_data, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic load_identity();
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    endtask

    task automatic push_expected();
        for (int i = 0; i < 256; i++) expq.push_back({i[7:0], mem[i]});
    endtask

    // Pulse start; returns at #1 after the accepting edge.
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one scan. stall_at >= 0 holds out_ready low for 5 cycles at that
    // word; ghost pulses start mid-scan and during DONE.
    task automatic run_scan(input int stall_at, input bit ghost, output int cycles);
        int  n;
        bit  stalled;
        n = 0;
        stalled = 1'b0;
        push_expected();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;     // start accepted at this edge
        start = 1'b0;
        n = 0;
        while (n < 2000) begin
            if (finish) break;
            if (stall_at >= 0 && !stalled && out_valid && out_addr == stall_at[7:0]) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    n++;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, stall_at);
                    chk("stall_address", address, stall_at);
                end
                out_ready = 1'b1;
            end
            if (ghost) start = (n == 100);
            @(posedge clk); #1;
            n++;
        end
        cycles = n;
        if (n >= 2000) chk("finish_timeout", 0, 1);
        chk("done_busy", busy, 1);
        if (ghost) start = 1'b1;   // start during DONE must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_finish", finish, 0);
        @(posedge clk); #1;
        chk("single_finish", finish, 0);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        load_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_address", address, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;

        // Clean identity scan: 768 edges from the accepting edge to DONE.
        run_scan(-1, 1'b0, cyc);
        chk("clean_cycles", cyc, 768);
        chk("clean_mismatch", mismatch, 0);
        chk("clean_err_count", err_count, 0);
        chk("clean_first_err", first_err_addr, 0);

        // Two bad words, stall at word 5, spurious starts mid-scan and in DONE.
        mem[8'h10] = 8'hAA;
        mem[8'h80] = 8'h00;
        run_scan(5, 1'b1, cyc);
        chk("stall_cycles", cyc, 773);
        chk("two_mismatch", mismatch, 1);
        chk("two_err_count", err_count, 2);
        chk("two_first_err", first_err_addr, 8'h10);
        repeat (3) @(posedge clk);
        #1;
        chk("held_err_count", err_count, 2);
        chk("held_busy", busy, 0);

        // New scan clears statistics.
        load_identity();
        run_scan(-1, 1'b0, cyc);
        chk("cleared_mismatch", mismatch, 0);
        chk("cleared_err_count", err_count, 0);

        // Every word wrong.
        for (int i = 0; i < 256; i++) mem[i] = ~i[7:0];
        run_scan(-1, 1'b0, cyc);
        chk("allwrong_mismatch", mismatch, 1);
        chk("allwrong_err_count", err_count, 256);
        chk("allwrong_first_err", first_err_addr, 0);
        chk("wren_low", wren_seen, 0);

        // Reset while presenting word 0x40.
        load_identity();
        mem[8'h20] = 8'h00;
        push_expected();
        pulse_start();
        cyc = 0;
        while (!(out_valid && out_addr == 8'h40) && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 1000) chk("reach_40_timeout", 0, 1);
        chk("pre_rst_mismatch", mismatch, 1);
        reset = 1'b1;
        start = 1'b1;          // reset must win over start
        @(posedge clk); #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_address", address, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_addr", out_addr, 0);
        chk("mid_rst_mismatch", mismatch, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_first_err", first_err_addr, 0);
        reset = 1'b0;
        start = 1'b0;
        expq.delete();
        mem[8'h20] = 8'h20;
        run_scan(-1, 1'b0, cyc);
        chk("restart_cycles", cyc, 768);
        chk("restart_err_count", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
